// File: rtl/gamma_corr_win.sv
// Sliding-window complex correlator: accumulates r_k*conj(r_{k-N}) over a runtime window of 1..L_MAX samples.
// Optional build macro GAMMA_SAT_EN saturates gamma_* to ACC_W bits; without it gamma_* wraps.
module gamma_corr_win #(
   parameter int IN_W     = 8,
   parameter int IN_FRAC  = 6,
   parameter int ACC_W    = 14,
   parameter int ACC_FRAC = 8,
   parameter int L_MAX    = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic [$clog2(L_MAX):0]      win_len,
   input  logic                        in_valid,
   input  logic signed [IN_W-1:0]      r_k_real,
   input  logic signed [IN_W-1:0]      r_k_imag,
   input  logic signed [IN_W-1:0]      r_kN_real,
   input  logic signed [IN_W-1:0]      r_kN_imag,
   output logic signed [ACC_W-1:0]     gamma_real,
   output logic signed [ACC_W-1:0]     gamma_imag,
   output logic                        gamma_valid
);

   localparam int LW         = $clog2(L_MAX);
   localparam int WL_W       = LW + 1;
   localparam int PW         = 2 * IN_W;
   localparam int SW         = PW + 1;
   localparam int SUM_W      = ACC_W + LW;
   localparam int PROD_SHIFT = 2 * IN_FRAC - ACC_FRAC;

`ifdef GAMMA_SAT_EN
   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
   localparam logic signed [SUM_W-1:0] SAT_LO = -SAT_HI - SUM_W'(1);
`endif

   function automatic logic [WL_W-1:0] clamp_len(input logic [WL_W-1:0] wl);
      if (wl == '0 || wl > WL_W'(L_MAX))
         return WL_W'(L_MAX);
      return wl;
   endfunction

   function automatic logic signed [ACC_W-1:0] map_out(input logic signed [SUM_W-1:0] s);
`ifdef GAMMA_SAT_EN
      if (s > SAT_HI)
         return ACC_W'(SAT_HI);
      if (s < SAT_LO)
         return ACC_W'(SAT_LO);
      return ACC_W'(s);
`else
      return ACC_W'(s);
`endif
   endfunction

   logic                     w_flush;
   logic                     r_vld_p1, r_vld_p2;
   logic signed [PW-1:0]     r_ac_p1, r_bd_p1, r_bc_p1, r_ad_p1;
   logic signed [SW-1:0]     w_re_sum, w_im_sum;
   logic signed [ACC_W-1:0]  r_prod_re_p2, r_prod_im_p2;

   logic signed [ACC_W-1:0]  r_hist_re [L_MAX];
   logic signed [ACC_W-1:0]  r_hist_im [L_MAX];
   logic [LW-1:0]            r_wr_ptr, w_rd_ptr;
   logic [WL_W-1:0]          r_fill, w_fill_nxt, r_win_len_q;
   logic                     w_full;
   logic signed [ACC_W-1:0]  w_old_re, w_old_im;
   logic signed [SUM_W-1:0]  r_sum_re, r_sum_im, w_sum_re_nxt, w_sum_im_nxt;

   assign w_flush = rst | clear;

   // Stage 1: four partial products
   always_ff @(posedge clk) begin
      if (w_flush)
         r_vld_p1 <= 1'b0;
      else
         r_vld_p1 <= in_valid;
      if (in_valid) begin
         r_ac_p1 <= PW'(r_k_real) * PW'(r_kN_real);
         r_bd_p1 <= PW'(r_k_imag) * PW'(r_kN_imag);
         r_bc_p1 <= PW'(r_k_imag) * PW'(r_kN_real);
         r_ad_p1 <= PW'(r_k_real) * PW'(r_kN_imag);
      end
   end

   // Stage 2: combine, floor-shift to ACC_FRAC, keep low ACC_W bits
   assign w_re_sum = SW'(r_ac_p1) + SW'(r_bd_p1);
   assign w_im_sum = SW'(r_bc_p1) - SW'(r_ad_p1);

   always_ff @(posedge clk) begin
      if (w_flush)
         r_vld_p2 <= 1'b0;
      else
         r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
         r_prod_re_p2 <= ACC_W'(w_re_sum >>> PROD_SHIFT);
         r_prod_im_p2 <= ACC_W'(w_im_sum >>> PROD_SHIFT);
      end
   end

   // Stage 3: circular history and running window sum
   assign w_rd_ptr     = r_wr_ptr - r_win_len_q[LW-1:0];
   assign w_full       = (r_fill >= r_win_len_q);
   assign w_old_re     = w_full ? r_hist_re[w_rd_ptr] : '0;
   assign w_old_im     = w_full ? r_hist_im[w_rd_ptr] : '0;
   assign w_sum_re_nxt = r_sum_re + SUM_W'(r_prod_re_p2) - SUM_W'(w_old_re);
   assign w_sum_im_nxt = r_sum_im + SUM_W'(r_prod_im_p2) - SUM_W'(w_old_im);
   assign w_fill_nxt   = w_full ? r_win_len_q : r_fill + WL_W'(1);

   always_ff @(posedge clk) begin
      if (w_flush) begin
         r_sum_re    <= '0;
         r_sum_im    <= '0;
         r_fill      <= '0;
         r_wr_ptr    <= '0;
         r_win_len_q <= clamp_len(win_len);
         gamma_real  <= '0;
         gamma_imag  <= '0;
         gamma_valid <= 1'b0;
      end else if (r_vld_p2) begin
         r_sum_re    <= w_sum_re_nxt;
         r_sum_im    <= w_sum_im_nxt;
         r_fill      <= w_fill_nxt;
         r_wr_ptr    <= r_wr_ptr + LW'(1);
         gamma_real  <= map_out(w_sum_re_nxt);
         gamma_imag  <= map_out(w_sum_im_nxt);
         gamma_valid <= (w_fill_nxt == r_win_len_q);
      end else begin
         gamma_valid <= 1'b0;
      end
   end

   // History is only wiped on rst; after clear the fill count masks stale entries
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < L_MAX; i++) begin
            r_hist_re[i] <= '0;
            r_hist_im[i] <= '0;
         end
      end else if (r_vld_p2 && !clear) begin
         r_hist_re[r_wr_ptr] <= r_prod_re_p2;
         r_hist_im[r_wr_ptr] <= r_prod_im_p2;
      end
   end

endmodule

// File: tb/tb_gamma_corr_win.sv
// Directed testbench for gamma_corr_win: fill, sign, overflow, bubbles, clear and reset scenarios.
module tb_gamma_corr_win;
   localparam int WL_W = 6;
`ifdef GAMMA_SAT_EN
   localparam int OVF_EXP = 8191;
`else
   localparam int OVF_EXP = 0;
`endif

   logic                clk = 1'b0;
   logic                rst, clear, in_valid;
   logic [WL_W-1:0]     win_len;
   logic signed [7:0]   ar, ai, cr, ci;
   logic signed [13:0]  g_re, g_im;
   logic                g_vld;

   int n_chk = 0;
   int n_fail = 0;
   int q_v[$], q_re[$], q_im[$];
   int pr[16], pim[16];
   int ov_re[$], ov_im[$];

   gamma_corr_win dut (
      .clk(clk), .rst(rst), .clear(clear), .win_len(win_len), .in_valid(in_valid),
      .r_k_real(ar), .r_k_imag(ai), .r_kN_real(cr), .r_kN_imag(ci),
      .gamma_real(g_re), .gamma_imag(g_im), .gamma_valid(g_vld)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input int a, input int b, input int c, input int d);
      in_valid = v;
      ar = 8'(a); ai = 8'(b); cr = 8'(c); ci = 8'(d);
      @(posedge clk);
      #1;
      q_v.push_back(int'(g_vld));
      q_re.push_back(int'(g_re));
      q_im.push_back(int'(g_im));
   endtask

   task automatic flush_q();
      q_v.delete(); q_re.delete(); q_im.delete();
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_re"}, int'(g_re), 0);
      check({tag, "_im"}, int'(g_im), 0);
      check({tag, "_vld"}, int'(g_vld), 0);
   endtask

   task automatic do_clear(input int wl, input logic v, input int a, input int b, input int c, input int d);
      clear = 1'b1;
      win_len = WL_W'(wl);
      step(v, a, b, c, d);
      clear = 1'b0;
      chk_zero("after_clear");
      flush_q();
   endtask

   task automatic collect_valid();
      ov_re.delete(); ov_im.delete();
      foreach (q_v[j]) if (q_v[j] == 1) begin
         ov_re.push_back(q_re[j]);
         ov_im.push_back(q_im[j]);
      end
   endtask

   task automatic chk_ramp(input string tag);
      int er, ei;
      check({tag, "_count"}, ov_re.size(), 9);
      for (int k = 7; k < 16; k++) begin
         er = 0; ei = 0;
         for (int m = k - 7; m <= k; m++) begin
            er += pr[m]; ei += pim[m];
         end
         check({tag, "_re"}, ov_re[k-7], er);
         check({tag, "_im"}, ov_im[k-7], ei);
      end
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; win_len = WL_W'(16);
      ar = '0; ai = '0; cr = '0; ci = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;

      // fill and steady state, window 16 latched at reset
      for (int k = 1; k <= 20; k++) step(1'b1, 64, 0, 64, 0);
      repeat (3) step(1'b0, 0, 0, 0, 0);
      check("fill_k15_vld", q_v[16], 0);
      check("fill_k16_vld", q_v[17], 1);
      check("fill_k16_re", q_re[17], 4096);
      check("fill_k16_im", q_im[17], 0);
      check("fill_k20_re", q_re[21], 4096);
      check("fill_bubble_vld", q_v[22], 0);
      check("fill_bubble_hold", q_re[22], 4096);
      collect_valid();
      check("fill_vld_count", ov_re.size(), 5);

      // imaginary sign
      do_clear(4, 1'b0, 0, 0, 0, 0);
      for (int k = 1; k <= 6; k++) step(1'b1, 0, 64, 64, 0);
      repeat (2) step(1'b0, 0, 0, 0, 0);
      check("imag_k3_vld", q_v[4], 0);
      check("imag_k4_vld", q_v[5], 1);
      check("imag_k4_im", q_im[5], 1024);
      check("imag_k4_re", q_re[5], 0);
      check("imag_k6_im", q_im[7], 1024);

      // overflow
      do_clear(16, 1'b0, 0, 0, 0, 0);
      for (int k = 1; k <= 16; k++) step(1'b1, -128, -128, -128, -128);
      repeat (2) step(1'b0, 0, 0, 0, 0);
      check("ovf_k16_vld", q_v[17], 1);
      check("ovf_k16_re", q_re[17], OVF_EXP);
      check("ovf_k16_im", q_im[17], 0);

      // bubbles vs contiguous ramp, window 8
      for (int i = 0; i < 16; i++) begin
         pr[i]  = (32 * i - 2 * i * i) >>> 4;
         pim[i] = (-16 * i - 4 * i * i) >>> 4;
      end
      do_clear(8, 1'b0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 4 * i, -2 * i, 8, i);
         step(1'b0, 99, 99, 99, 99);
      end
      repeat (2) step(1'b0, 0, 0, 0, 0);
      check("bub_gap_vld", q_v[23], 0);
      check("bub_gap_hold", q_re[23], pr[3] + pr[4] + pr[5] + pr[6] + pr[7] + pr[8] + pr[9] + pr[10]);
      collect_valid();
      chk_ramp("bub");
      do_clear(8, 1'b0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(1'b1, 4 * i, -2 * i, 8, i);
      repeat (2) step(1'b0, 0, 0, 0, 0);
      collect_valid();
      chk_ramp("contig");

      // clear with a coincident sample and a window change to 4
      do_clear(16, 1'b0, 0, 0, 0, 0);
      for (int k = 1; k <= 18; k++) step(1'b1, 64, 0, 64, 0);
      do_clear(4, 1'b1, -128, 0, -128, 0);
      for (int k = 1; k <= 6; k++) step(1'b1, 16 * k, 0, 64, 0);
      repeat (2) step(1'b0, 0, 0, 0, 0);
      check("clr_pipe0_vld", q_v[0], 0);
      check("clr_pipe1_vld", q_v[1], 0);
      check("clr_k1_vld", q_v[2], 0);
      check("clr_k2_vld", q_v[3], 0);
      check("clr_k3_vld", q_v[4], 0);
      check("clr_k4_vld", q_v[5], 1);
      check("clr_k4_re", q_re[5], 640);
      check("clr_k5_re", q_re[6], 896);
      check("clr_k6_re", q_re[7], 1152);

      // reset mid-operation with S1 and S2 occupied, new window 2
      step(1'b1, 64, 0, 64, 0);
      step(1'b1, 64, 0, 64, 0);
      rst = 1'b1;
      win_len = WL_W'(2);
      step(1'b0, 0, 0, 0, 0);
      rst = 1'b0;
      chk_zero("mid_rst");
      flush_q();
      repeat (3) step(1'b0, 0, 0, 0, 0);
      collect_valid();
      check("mid_rst_no_vld", ov_re.size(), 0);
      flush_q();
      for (int k = 1; k <= 3; k++) step(1'b1, 64, 0, 64, 0);
      repeat (2) step(1'b0, 0, 0, 0, 0);
      check("rst_k1_vld", q_v[2], 0);
      check("rst_k2_vld", q_v[3], 1);
      check("rst_k2_re", q_re[3], 512);
      check("rst_k3_re", q_re[4], 512);

      // win_len of 0 selects the full L_MAX window
      do_clear(0, 1'b0, 0, 0, 0, 0);
      for (int k = 1; k <= 33; k++) step(1'b1, 8, 0, 8, 0);
      repeat (2) step(1'b0, 0, 0, 0, 0);
      check("clamp_k31_vld", q_v[32], 0);
      check("clamp_k32_vld", q_v[33], 1);
      check("clamp_k32_re", q_re[33], 128);
      check("clamp_k33_re", q_re[34], 128);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
